// File: rtl/maze_pkg.sv
// Shared maze definitions: move encoding, replay state type and default coordinate width.
package maze_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // The row is the axis when the move bits are equal; bit 0 selects increment.
  localparam logic [1:0] MOVE_UP    = 2'b00;
  localparam logic [1:0] MOVE_DOWN  = 2'b11;
  localparam logic [1:0] MOVE_RIGHT = 2'b01;
  localparam logic [1:0] MOVE_LEFT  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT  = 2'd1,
    FETCH = 2'd2,
    DONE  = 2'd3
  } replayStateT;

endpackage

// File: rtl/coord_step.sv
// Combinational single-step coordinate update with grid-edge detection.
// Also used by the solver for its bounds checks.
module coord_step
  import maze_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] row,
  input  logic [WIDTH-1:0] col,
  input  logic [1:0]       move,
  output logic [WIDTH-1:0] next_row,
  output logic [WIDTH-1:0] next_col,
  output logic             oob
);

  localparam logic [WIDTH-1:0] MAX_COORD = '1;
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  logic             rowAxis;
  logic             increment;
  logic [WIDTH-1:0] axisVal;
  logic [WIDTH-1:0] stepped;

  always_comb begin
    rowAxis   = ~(move[1] ^ move[0]);
    increment = move[0];
    axisVal   = rowAxis ? row : col;
    oob       = increment ? (axisVal == MAX_COORD) : (axisVal == '0);
    stepped   = increment ? (axisVal + ONE) : (axisVal - ONE);
    next_row  = row;
    next_col  = col;
    // An out-of-grid move leaves the coordinate untouched rather than wrapping.
    if (!oob) begin
      if (rowAxis) next_row = stepped;
      else         next_col = stepped;
    end
  end

endmodule

// File: rtl/path_replayer.sv
// Drains the solver's path queue and streams the visited cells over valid/ready.
// Optional PATH_STEP_COUNT_EN adds a saturating step_count output.
module path_replayer
  import maze_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int START_ROW = 0,
  parameter int START_COL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       q_move,
  input  logic             q_empty,
  output logic             q_pop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_row,
  output logic [WIDTH-1:0] out_col,
  output logic [1:0]       out_move,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef PATH_STEP_COUNT_EN
  ,
  output logic [WIDTH+3:0] step_count
`endif
);

  localparam logic [WIDTH-1:0] ROW_START = WIDTH'(START_ROW);
  localparam logic [WIDTH-1:0] COL_START = WIDTH'(START_COL);

  replayStateT      state;
  logic [WIDTH-1:0] rowReg;
  logic [WIDTH-1:0] colReg;
  logic [1:0]       moveReg;
  logic             popReg;
  logic             validReg;
  logic             busyReg;
  logic             doneReg;
  logic             errReg;

  logic [WIDTH-1:0] stepRow;
  logic [WIDTH-1:0] stepCol;
  logic             stepOob;
  logic             accept;
  logic             startTake;

  coord_step #(.WIDTH(WIDTH)) uStep (
    .row      (rowReg),
    .col      (colReg),
    .move     (q_move),
    .next_row (stepRow),
    .next_col (stepCol),
    .oob      (stepOob)
  );

  assign accept    = validReg & out_ready;
  assign startTake = start & ((state == IDLE) | (state == DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rowReg   <= ROW_START;
      colReg   <= COL_START;
      moveReg  <= MOVE_UP;
      popReg   <= 1'b0;
      validReg <= 1'b0;
      busyReg  <= 1'b0;
      doneReg  <= 1'b0;
      errReg   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= EMIT;
            rowReg   <= ROW_START;
            colReg   <= COL_START;
            moveReg  <= MOVE_UP;
            errReg   <= 1'b0;
            validReg <= 1'b1;
            busyReg  <= 1'b1;
            doneReg  <= 1'b0;
          end
        end
        EMIT: begin
          if (accept) begin
            validReg <= 1'b0;
            if (q_empty) begin
              state   <= DONE;
              busyReg <= 1'b0;
              doneReg <= 1'b1;
            end else begin
              state  <= FETCH;
              popReg <= 1'b1;
            end
          end
        end
        FETCH: begin
          // The popped move is consumed even when it would leave the grid.
          popReg <= 1'b0;
          if (stepOob) begin
            state   <= DONE;
            errReg  <= 1'b1;
            busyReg <= 1'b0;
            doneReg <= 1'b1;
          end else begin
            state    <= EMIT;
            rowReg   <= stepRow;
            colReg   <= stepCol;
            moveReg  <= q_move;
            validReg <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PATH_STEP_COUNT_EN
  logic [WIDTH+3:0] stepCountReg;
  logic             firstBeatReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stepCountReg <= '0;
      firstBeatReg <= 1'b0;
    end else if (startTake) begin
      stepCountReg <= '0;
      firstBeatReg <= 1'b1;
    end else if (accept) begin
      firstBeatReg <= 1'b0;
      // The start-cell beat is not a step; the count saturates instead of wrapping.
      if (!firstBeatReg && (stepCountReg != '1))
        stepCountReg <= stepCountReg + (WIDTH+4)'(1);
    end
  end

  assign step_count = stepCountReg;
`endif

  assign q_pop     = popReg;
  assign out_valid = validReg;
  assign out_row   = rowReg;
  assign out_col   = colReg;
  assign out_move  = moveReg;
  assign out_last  = validReg & q_empty;
  assign busy      = busyReg;
  assign done      = doneReg;
  assign err       = errReg;

endmodule
